arb_mux: RTL and testbench
==========================

Name: arb_mux

Overview:
Parametrised N-channel registered multiplexer with a valid/ready handshake on every input and on the output. It replaces fixed-select Mux2/Mux3/Mux4 instances wherever several producers share one consumer, e.g. multiple writeback or bus sources feeding one register-file port or memory interface. Channel selection is internal (fixed-priority or round-robin arbitration), with an optional external override. The output passes through one pipeline register stage with stall and flush support.

Parameters:
WIDTH, 32, data width per channel (1..64)
CHANNELS, 4, number of input channels (2..16)
SEL_W, 2, width of channel index; must equal $clog2(CHANNELS)
RR, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel request
in_ready  output  CHANNELS  per-channel grant/accept (combinational)
force_en  input  1  1 = bypass arbitration, use force_sel
force_sel  input  SEL_W  forced channel index when force_en=1
flush  input  1  discard registered output, accept nothing this cycle
out_data  output  WIDTH  registered selected data
out_chan  output  SEL_W  registered index of the channel that produced out_data
out_valid  output  1  out_data/out_chan valid
out_ready  input  1  consumer accepts output

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. in_ready is combinational and reads 0 during reset.
- accept = ~flush & ~reset & (~out_valid | out_ready).
- Grant, when force_en=0:
  - RR=0: grant the lowest-index i with in_valid[i]=1.
  - RR=1: grant the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with modulo-CHANNELS wrap.
- Grant, when force_en=1: grant = force_sel only if in_valid[force_sel]=1, otherwise no grant. A force_sel value >= CHANNELS never grants.
- in_ready[i] = accept & grant[i]. At most one bit is set; in_ready[i] may be 1 only when in_valid[i]=1.
- Transfer on channel g (in_valid[g] & in_ready[g]): at the next edge out_data <= in_data[g], out_chan <= g, out_valid <= 1. Latency is 1 cycle.
- If accept=1 and there is no grant: out_valid <= 0. out_data and out_chan hold their values.
- Stall (out_valid=1, out_ready=0, flush=0): out_data, out_chan and out_valid hold stable. All in_ready are 0.
- Simultaneous drain and load (out_valid=1, out_ready=1, grant present): new data loads the same edge. Full throughput is 1 transfer/cycle.
- flush=1: out_valid <= 0, all in_ready=0, rr_ptr unchanged. flush has priority over out_ready. out_data/out_chan hold.
- rr_ptr updates only on a transfer: rr_ptr <= (g == CHANNELS-1) ? 0 : g+1. Forced transfers also advance rr_ptr. When RR=0, rr_ptr is unused.
- Reset asserted mid-stall: the held output is dropped and out_valid=0 the following cycle.
- No combinational path from out_ready to out_data. A path from out_ready to in_ready is permitted.

Test Plan:
- Reset, then in_valid=4'b0000 for 3 cycles -> out_valid=0, out_data=0, out_chan=0, in_ready=0 throughout.
- RR=1, in_valid=4'b1111 held, out_ready=1, channel i data=0xA0+i -> out_chan sequence 0,1,2,3,0 on consecutive cycles; out_data 0xA0,0xA1,0xA2,0xA3,0xA0; one in_ready bit per cycle.
- RR=0, same stimulus -> out_chan=0 every cycle, in_ready=4'b0001 every cycle.
- Load ch2=0x1234, then out_ready=0 for 3 cycles with in_valid=4'b1111 -> out_data=0x1234, out_chan=2 stable, in_ready=0. Then out_ready=1 -> next grant is ch3 (RR=1).
- force_en=1, force_sel=1, in_valid=4'b0101 -> no grant, out_valid=0. Then in_valid=4'b0111 -> in_ready=4'b0010, out_chan=1 next cycle, rr_ptr=2.
- flush=1 while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, in_ready=0 during flush. rr_ptr is unchanged, verified by the next grant order.

Source files
------------

// File: rtl/arb_mux.sv
// -----------------------------------------------------------------------------
// arb_mux
//   N-channel arbitrated multiplexer with one registered output stage. Several
//   producers share one consumer through valid/ready handshakes. The channel is
//   picked internally by fixed priority or round-robin arbitration. An external
//   override can also select it. The output register supports stall and flush.
//
// Parameters
//   WIDTH     data width per channel (1..64)
//   CHANNELS  number of input channels (2..16)
//   SEL_W     channel index width, equal to $clog2(CHANNELS)
//   RR        0 = fixed priority (lowest index wins), 1 = round-robin
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept (combinational, at most one bit set)
//   force_en   bypass arbitration and use force_sel
//   force_sel  forced channel index
//   flush      drop the registered output and accept nothing this cycle
//   out_data   registered selected data
//   out_chan   registered index of the channel that produced out_data
//   out_valid  out_data/out_chan are valid
//   out_ready  consumer accepts the output
// -----------------------------------------------------------------------------
module arb_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int RR       = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic                  accept;
    logic                  gnt_any;
    logic [SEL_W-1:0]      gnt_idx;
    logic [CHANNELS-1:0]   grant;
    logic [WIDTH-1:0]      sel_data;
    logic [SEL_W-1:0]      rr_ptr;
    logic [2*CHANNELS-1:0] rr_window;
    int                    rr_sum;

    // The output register can take new data when it is empty or draining.
    assign accept = ~flush & ~reset & (~out_valid | out_ready);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        rr_sum    = 0;
        rr_window = {in_valid, in_valid} >> rr_ptr;

        if (force_en) begin
            // Indices at or above CHANNELS never match, so they never grant.
            for (int i = 0; i < CHANNELS; i++) begin
                if (SEL_W'(i) == force_sel && in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else if (RR == 0) begin
            // Scan downwards so the lowest requesting index is written last.
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            // rr_window holds the requests rotated so that bit 0 is channel rr_ptr.
            // The lowest set bit is the distance from rr_ptr to the winner.
            for (int j = CHANNELS - 1; j >= 0; j--) begin
                if (rr_window[j]) begin
                    gnt_any = 1'b1;
                    rr_sum  = int'(rr_ptr) + j;
                end
            end
            if (rr_sum >= CHANNELS) begin
                rr_sum = rr_sum - CHANNELS;
            end
            gnt_idx = SEL_W'(rr_sum);
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == gnt_idx) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grant    = gnt_any ? (CHANNELS'(1) << gnt_idx) : '0;
    assign in_ready = accept ? grant : '0;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            // Data and channel hold. Only the valid flag is dropped.
            out_valid <= 1'b0;
        end else if (accept) begin
            if (gnt_any) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_chan  <= gnt_idx;
                // Forced transfers advance the pointer too. The pointer is unused when RR=0.
                if (int'(gnt_idx) == CHANNELS - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= gnt_idx + SEL_W'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_arb_mux
//   Directed bench for arb_mux. It drives one round-robin instance and one
//   fixed-priority instance from shared stimulus. The driver applies
//   hand-written vectors and checks in_ready against the expected grant. For
//   each expected transfer it pushes {data, chan} into that instance's queue.
//   A monitor pops the queue and compares whenever the output handshakes.
// -----------------------------------------------------------------------------
module tb_arb_mux;

    localparam int W  = 32;
    localparam int CH = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SW-1:0] chan;
    } item_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic            force_en;
    logic [SW-1:0]   force_sel;
    logic            flush;
    logic            out_ready;

    logic [CH-1:0]   in_ready_rr, in_ready_fp;
    logic [W-1:0]    out_data_rr, out_data_fp;
    logic [SW-1:0]   out_chan_rr, out_chan_fp;
    logic            out_valid_rr, out_valid_fp;

    logic [W-1:0]    ch_data [CH];
    item_t           q_rr[$];
    item_t           q_fp[$];
    int              active;   // 1 = round-robin instance under check, 0 = fixed priority
    int              n_checks = 0;
    int              n_fail   = 0;

    assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .RR(1)) u_rr (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_rr), .force_en(force_en), .force_sel(force_sel),
        .flush(flush), .out_data(out_data_rr), .out_chan(out_chan_rr),
        .out_valid(out_valid_rr), .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .RR(0)) u_fp (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_fp), .force_en(force_en), .force_sel(force_sel),
        .flush(flush), .out_data(out_data_fp), .out_chan(out_chan_fp),
        .out_valid(out_valid_fp), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge. At the falling
    // edge, check the combinational grant and queue the expected transfer.
    task automatic step(input logic [CH-1:0] v, input logic fe, input logic [SW-1:0] fs,
                        input logic ordy, input logic fl, input logic [CH-1:0] exp_rdy,
                        input logic push);
        item_t it;
        @(posedge clk);
        #1;
        in_valid  = v;
        force_en  = fe;
        force_sel = fs;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check("in_ready", active == 1 ? in_ready_rr : in_ready_fp, exp_rdy);
        if (push) begin
            it.chan = '0;
            for (int i = 0; i < CH; i++) begin
                if (exp_rdy[i]) it.chan = SW'(i);
            end
            it.data = ch_data[it.chan];
            if (active == 1) q_rr.push_back(it);
            else             q_fp.push_back(it);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        in_valid  = '1;
        force_en  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", active == 1 ? in_ready_rr : in_ready_fp, '0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = '0;
    endtask

    // Scoreboard monitors: a transfer leaves the output at the next edge.
    always @(negedge clk) begin
        item_t e;
        if (active == 1 && !reset && !flush && out_ready && out_valid_rr) begin
            if (q_rr.size() == 0) begin
                check("sb_rr_unexpected_output", 1, 0);
            end else begin
                e = q_rr.pop_front();
                check("sb_rr_data", out_data_rr, e.data);
                check("sb_rr_chan", out_chan_rr, e.chan);
            end
        end
    end

    always @(negedge clk) begin
        item_t e;
        if (active == 0 && !reset && !flush && out_ready && out_valid_fp) begin
            if (q_fp.size() == 0) begin
                check("sb_fp_unexpected_output", 1, 0);
            end else begin
                e = q_fp.pop_front();
                check("sb_fp_data", out_data_fp, e.data);
                check("sb_fp_chan", out_chan_fp, e.chan);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        force_en  = 1'b0;
        force_sel = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        active    = 1;
        for (int i = 0; i < CH; i++) ch_data[i] = W'(32'hA0 + i);

        // Idle after reset: nothing granted, outputs stay at their reset values.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0);
            check("idle_rr_valid", out_valid_rr, 0);
            check("idle_rr_data",  out_data_rr,  0);
            check("idle_rr_chan",  out_chan_rr,  0);
            check("idle_fp_valid", out_valid_fp, 0);
            check("idle_fp_data",  out_data_fp,  0);
            check("idle_fp_chan",  out_chan_fp,  0);
            check("idle_fp_in_ready", in_ready_fp, 0);
        end

        // Round-robin with every channel requesting: 0,1,2,3 then wrap to 0.
        step(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1);
        step(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0010, 1'b1);
        step(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0100, 1'b1);
        step(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1000, 1'b1);
        step(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1);
        step(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0);

        // Fixed priority with the same stimulus: channel 0 wins every cycle.
        active = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1);
        end
        step(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0);

        // Stall: load channel 2, hold for three cycles, then resume at channel 3.
        active = 1;
        do_reset();
        ch_data[2] = 32'h0000_1234;
        step(4'b0100, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0100, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
            check("stall_valid", out_valid_rr, 1);
            check("stall_data",  out_data_rr,  32'h0000_1234);
            check("stall_chan",  out_chan_rr,  2);
        end
        step(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1000, 1'b1);
        step(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0);
        ch_data[2] = 32'hA2;

        // Force: the forced channel is not requesting, so nothing is granted.
        step(4'b0101, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(4'b0111, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 1'b1);
        check("force_nogrant_valid", out_valid_rr, 0);
        // The forced transfer moved rr_ptr to 2. This channel-2 load is flushed next.
        step(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0100, 1'b0);

        // Flush during a stall: the output is dropped and rr_ptr stays at 3.
        step(4'b1111, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
        check("preflush_valid", out_valid_rr, 1);
        check("preflush_chan",  out_chan_rr,  2);
        step(4'b1111, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
        check("postflush_valid", out_valid_rr, 0);
        step(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1000, 1'b1);
        step(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1);
        step(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0);

        check("sb_rr_leftover", q_rr.size(), 0);
        check("sb_fp_leftover", q_fp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
